int_alu_dispatch: RTL and testbench
===================================

INT_ALU_DISPATCH -- requirements
Module: int_alu_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles spent in ISSUE+WAIT before abort (legal range 2..1024).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  decode side presents an integer operation.
REQ-005 SHALL have port req_ready  out  1  block accepts a request this cycle.
REQ-006 SHALL have ports req_op1, req_op2  in  32 each  signed operands.
REQ-007 SHALL have port req_operation  in  4  ALU operation code: 00xx add/sub/mul/div, 01xx not/and/or/xor, 1xxx write-high/write-low/itof/ftoi.
REQ-008 SHALL have port req_dst  in  5  destination register tag.
REQ-009 SHALL have ports alu_op1, alu_op2  out  32 each  and alu_operation  out  4  driven to the integer ALU.
REQ-010 SHALL have port alu_en  out  1  ALU start request.
REQ-011 SHALL have ports alu_en_knock_down  in  1  ALU acknowledges start; alu_done  in  1  result valid; alu_out  in  32  result; alu_flag  in  2  flags.
REQ-012 SHALL have ports wb_valid  out  1;  wb_ready  in  1;  wb_data  out  32;  wb_flag  out  2;  wb_dst  out  5;  wb_timeout  out  1  (writeback side).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: req_ready=1, alu_en=0; on req_valid, SHALL register op1/op2/operation/dst and go to ISSUE next cycle.
REQ-015 req_ready SHALL be 1 only in IDLE; requests in other states are not accepted.
REQ-016 alu_op1/alu_op2/alu_operation SHALL come from the registered copies and stay stable from ISSUE entry until RESP exit.
REQ-017 ISSUE: alu_en=1; knock_down and done in the same cycle -> capture, go to RESP; knock_down without done -> WAIT; neither -> remain in ISSUE.
REQ-018 WAIT: alu_en=0; on alu_done -> capture alu_out into wb_data and alu_flag into wb_flag, set wb_timeout=0, go to RESP.
REQ-019 alu_done and alu_en_knock_down SHALL be ignored in IDLE and RESP.
REQ-020 Timeout counter SHALL clear on ISSUE entry and increment each cycle in ISSUE or WAIT.
REQ-021 Timeout: at count TIMEOUT-1 with no alu_done, SHALL go to RESP with wb_data=0, wb_flag=0, wb_timeout=1, alu_en=0.
REQ-022 alu_done SHALL take priority over timeout in the same cycle.
REQ-023 RESP: wb_valid=1; wb_data/wb_flag/wb_dst/wb_timeout SHALL hold stable until a wb_valid&&wb_ready cycle, then go to IDLE.
REQ-024 Latency: a single-cycle op accepted at cycle T SHALL show wb_valid at T+2; a multi-cycle op shows wb_valid the cycle after alu_done; minimum repeat interval is 3 cycles.
REQ-025 wb_dst SHALL equal the req_dst registered at acceptance.

Reset
REQ-026 On rst assertion, at any time, the block SHALL immediately go to IDLE and clear all registers and outputs to 0, except req_ready=1 once IDLE is entered.
REQ-027 Reset mid-operation SHALL discard the in-flight result with no writeback; alu_en SHALL drop asynchronously.
REQ-028 After rst deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-029 XOR: op1=0xF0F00000, op2=0x0FF00000, op=0111, model returns done+knock_down in ISSUE -> wb_valid at T+2, wb_data=0xFF000000, wb_timeout=0.
REQ-030 ADD: op1=5, op2=7, op=0000, model returns knock_down in ISSUE, done 4 cycles later with flag=2'b00 -> wb_data=12, wb_valid the cycle after done.
REQ-031 Backpressure: wb_ready=0 for 10 cycles in RESP -> wb_valid, wb_data, wb_dst stable and req_ready=0 throughout; IDLE one cycle after wb_ready=1.
REQ-032 Timeout: TIMEOUT=8, model never asserts done -> RESP 8 cycles after ISSUE entry with wb_timeout=1, wb_data=0.
REQ-033 Reset during WAIT -> alu_en=0, wb_valid=0, state IDLE; the next request (op=1000, op1=0x1234, op2=0xABCD) completes with wb_data=0xABCD1234.
REQ-034 alu_done held high in IDLE with req_valid=0 -> no wb_valid and no state change.

Source files
------------

// File: rtl/int_alu_dispatch_if.sv
// Bundle of the decode-side request, integer-ALU handshake and writeback
// signals for int_alu_dispatch. The dispatcher uses the slave view. The
// environment (decode stage, ALU and writeback) uses the master view.
interface int_alu_dispatch_if;
  // decode side
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  req_operation;
  logic [4:0]  req_dst;
  // integer ALU side
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_operation;
  logic        alu_en;
  logic        alu_en_knock_down;
  logic        alu_done;
  logic [31:0] alu_out;
  logic [1:0]  alu_flag;
  // writeback side
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [1:0]  wb_flag;
  logic [4:0]  wb_dst;
  logic        wb_timeout;

  modport slave (
    input  req_valid, req_op1, req_op2, req_operation, req_dst,
    input  alu_en_knock_down, alu_done, alu_out, alu_flag,
    input  wb_ready,
    output req_ready, alu_op1, alu_op2, alu_operation, alu_en,
    output wb_valid, wb_data, wb_flag, wb_dst, wb_timeout
  );

  modport master (
    output req_valid, req_op1, req_op2, req_operation, req_dst,
    output alu_en_knock_down, alu_done, alu_out, alu_flag,
    output wb_ready,
    input  req_ready, alu_op1, alu_op2, alu_operation, alu_en,
    input  wb_valid, wb_data, wb_flag, wb_dst, wb_timeout
  );
endinterface

// File: rtl/int_alu_dispatch.sv
// Integer ALU dispatcher. It accepts one operation from decode and starts
// the integer ALU. It then waits for the ALU result, or gives up after
// TIMEOUT cycles. Finally it holds the result on the writeback port until
// that port accepts it.
module int_alu_dispatch #(
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  int_alu_dispatch_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       op1_reg, op1_next;
  logic [31:0]       op2_reg, op2_next;
  logic [3:0]        operation_reg, operation_next;
  logic [4:0]        dst_reg, dst_next;
  logic [31:0]       data_reg, data_next;
  logic [1:0]        flag_reg, flag_next;
  logic              timeout_reg, timeout_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // State and datapath registers. Reset is asynchronous, so alu_en and
  // wb_valid (both decoded from state) drop as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op1_reg       <= '0;
      op2_reg       <= '0;
      operation_reg <= '0;
      dst_reg       <= '0;
      data_reg      <= '0;
      flag_reg      <= '0;
      timeout_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      op1_reg       <= op1_next;
      op2_reg       <= op2_next;
      operation_reg <= operation_next;
      dst_reg       <= dst_next;
      data_reg      <= data_next;
      flag_reg      <= flag_next;
      timeout_reg   <= timeout_next;
      cnt_reg       <= cnt_next;
    end
  end

  // Next-state and next-datapath logic. A result (or the timeout marker)
  // is captured only on the transition into RESP. It therefore stays
  // frozen for the whole writeback stall.
  always_comb begin
    state_next     = state_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    operation_next = operation_reg;
    dst_next       = dst_reg;
    data_next      = data_reg;
    flag_next      = flag_reg;
    timeout_next   = timeout_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE: begin
        // ALU handshakes are ignored here. Only a request moves us on.
        if (bus.req_valid) begin
          op1_next       = bus.req_op1;
          op2_next       = bus.req_op2;
          operation_next = bus.req_operation;
          dst_next       = bus.req_dst;
          cnt_next       = '0;
          state_next     = ISSUE;
        end
      end

      ISSUE, WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // Done wins over the timeout when both happen in the same cycle.
        // A done seen while still issuing implies that the start was taken.
        if (bus.alu_done) begin
          data_next    = bus.alu_out;
          flag_next    = bus.alu_flag;
          timeout_next = 1'b0;
          state_next   = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          data_next    = '0;
          flag_next    = '0;
          timeout_next = 1'b1;
          state_next   = RESP;
        end else if (state_reg == ISSUE && bus.alu_en_knock_down) begin
          state_next = WAIT;
        end
      end

      RESP: begin
        if (bus.wb_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state. Operand and result
  // outputs come straight from their holding registers.
  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.alu_en        = (state_reg == ISSUE);
  assign bus.alu_op1       = op1_reg;
  assign bus.alu_op2       = op2_reg;
  assign bus.alu_operation = operation_reg;
  assign bus.wb_valid      = (state_reg == RESP);
  assign bus.wb_data       = data_reg;
  assign bus.wb_flag       = flag_reg;
  assign bus.wb_dst        = dst_reg;
  assign bus.wb_timeout    = timeout_reg;

endmodule

// File: tb/tb_int_alu_dispatch.sv
// Self-checking bench for int_alu_dispatch. The stimulus process plays
// both the decode stage and the integer ALU. Every accepted request pushes
// its expected writeback into a queue. An independent monitor pops and
// compares that entry on each writeback handshake.
module tb_int_alu_dispatch;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_alu_dispatch_if bus ();

  int_alu_dispatch #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  flag;
    logic [4:0]  dst;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total = 0;
  int   checks_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (act === req) checks_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference ALU behaviour: {flag, data}. The flag is {sign, zero}. The
  // conversion codes use simple stand-ins because the dispatcher never
  // looks at the data.
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] opc);
    logic [31:0] d;
    case (opc)
      4'd0:  d = a + b;
      4'd1:  d = a - b;
      4'd2:  d = a * b;
      4'd3:  d = (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? a
                 : 32'($signed(a) / $signed(b));
      4'd4:  d = ~a;
      4'd5:  d = a & b;
      4'd6:  d = a | b;
      4'd7:  d = a ^ b;
      4'd8:  d = {b[15:0], a[15:0]};
      4'd9:  d = {a[31:16], b[15:0]};
      4'd10: d = a;
      4'd11: d = b;
      default: d = 32'd0;
    endcase
    return {d[31], (d == 32'd0), d};
  endfunction

  // Monitor: compare on each writeback handshake, and check that a stalled
  // writeback holds its value.
  exp_t cur, held, popped;
  bit   stall_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        cur.data    = bus.wb_data;
        cur.flag    = bus.wb_flag;
        cur.dst     = bus.wb_dst;
        cur.timeout = bus.wb_timeout;
        if (stall_prev) check("wb_hold", {bus.wb_valid, cur}, {1'b1, held});
        if (bus.wb_valid && bus.wb_ready) begin
          if (exp_q.size() == 0) begin
            checks_total++;
            $display("FAIL wb_unexpected: got writeback data %h dst %0d, expected none",
                     bus.wb_data, bus.wb_dst);
          end else begin
            popped = exp_q.pop_front();
            check("wb_result", cur, popped);
          end
          stall_prev = 0;
        end else if (bus.wb_valid) begin
          stall_prev = 1;
          held       = cur;
        end else begin
          stall_prev = 0;
        end
      end
    end
  end

  // One full transaction. kd and dn are the ALU knock-down and done cycles,
  // counted from ISSUE entry (dn < 0 means no done). hold is the number of
  // RESP cycles with wb_ready low.
  task automatic run_txn(input logic [31:0] op1, input logic [31:0] op2, input logic [3:0] opc,
                         input logic [4:0] dst, input int kd, input int dn, input int hold);
    exp_t        e;
    logic [33:0] r;
    logic [33:0] r2;
    bit          timed_out;
    int          last;
    int          guard;
    r         = alu_ref(op1, op2, opc);
    timed_out = !(dn >= 0 && dn <= TO - 1);
    e.data    = timed_out ? 32'd0 : r[31:0];
    e.flag    = timed_out ? 2'd0 : r[33:32];
    e.dst     = dst;
    e.timeout = timed_out;

    bus.wb_ready      = (hold == 0);
    bus.req_valid     = 1'b1;
    bus.req_op1       = op1;
    bus.req_op2       = op2;
    bus.req_operation = opc;
    bus.req_dst       = dst;
    guard = 0;
    while (!bus.req_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        check("req_accept_wait", guard, 0);
        bus.req_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble the request bus so that only the registered copies are valid.
    bus.req_valid     = 1'b0;
    bus.req_op1       = $urandom;
    bus.req_op2       = $urandom;
    bus.req_operation = 4'($urandom);
    bus.req_dst       = 5'($urandom);

    last = timed_out ? TO - 1 : dn;
    for (int c = 0; c <= last; c++) begin
      check("alu_en", bus.alu_en, (c <= kd));
      check("alu_operands", {bus.alu_op1, bus.alu_op2, bus.alu_operation}, {op1, op2, opc});
      check("req_ready_busy", bus.req_ready, 0);
      bus.alu_en_knock_down = (c == kd);
      bus.alu_done          = (c == dn);
      r2 = alu_ref(bus.alu_op1, bus.alu_op2, bus.alu_operation);
      bus.alu_out  = (c == dn) ? r2[31:0] : $urandom;
      bus.alu_flag = (c == dn) ? r2[33:32] : 2'($urandom);
      @(posedge clk); #1;
      if (c < last) check("wb_valid_early", bus.wb_valid, 0);
    end
    bus.alu_en_knock_down = 1'b0;
    bus.alu_done          = 1'b0;
    check("wb_valid_latency", bus.wb_valid, 1);
    check("alu_en_resp", bus.alu_en, 0);
    // A late done during RESP must not disturb the captured result.
    if (timed_out) begin
      bus.alu_done = 1'b1;
      bus.alu_out  = $urandom | 32'h1;
      bus.alu_flag = 2'b11;
    end
    for (int h = 0; h < hold; h++) begin
      check("req_ready_resp", bus.req_ready, 0);
      @(posedge clk); #1;
      bus.alu_done = 1'b0;
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    check("idle_after_wb", bus.req_ready, 1);
  endtask

  // Start a request, then assert reset in ISSUE (kd < 0) or in WAIT
  // (kd = 0). The in-flight result must vanish.
  task automatic reset_mid(input int kd);
    bus.req_valid     = 1'b1;
    bus.req_op1       = 32'hDEAD_BEEF;
    bus.req_op2       = 32'h1;
    bus.req_operation = 4'd0;
    bus.req_dst       = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_pre_alu_en", bus.alu_en, 1);
    bus.alu_en_knock_down = (kd == 0);
    @(posedge clk); #1;
    bus.alu_en_knock_down = 1'b0;
    if (kd == 0) check("rst_pre_wait", bus.alu_en, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_alu_en", bus.alu_en, 0);
    check("rst_async_wb_valid", bus.wb_valid, 0);
    check("rst_async_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    check("rst_hold_wb_data", bus.wb_data, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int kd, dn, hold;
    rst                   = 1'b1;
    bus.req_valid         = 1'b0;
    bus.req_op1           = '0;
    bus.req_op2           = '0;
    bus.req_operation     = '0;
    bus.req_dst           = '0;
    bus.alu_en_knock_down = 1'b0;
    bus.alu_done          = 1'b0;
    bus.alu_out           = '0;
    bus.alu_flag          = '0;
    bus.wb_ready          = 1'b1;
    #1;
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_alu_en", bus.alu_en, 0);
    check("reset_wb_valid", bus.wb_valid, 0);
    check("reset_wb_fields", {bus.wb_data, bus.wb_flag, bus.wb_dst, bus.wb_timeout}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle XOR, the first request after reset.
    run_txn(32'hF0F0_0000, 32'h0FF0_0000, 4'b0111, 5'd3, 0, 0, 0);
    // Multi-cycle ADD: knock-down on issue, done four cycles later.
    run_txn(32'd5, 32'd7, 4'b0000, 5'd4, 0, 4, 0);
    // Writeback stalled for 10 cycles.
    run_txn(32'h1111_2222, 32'h0000_3333, 4'b0110, 5'd17, 1, 2, 10);
    // No done ever: timeout after TO cycles, and a late done in RESP.
    run_txn(32'd9, 32'd9, 4'b0010, 5'd22, 0, -1, 2);
    // Done lands on the last counted cycle, so it beats the timeout.
    run_txn(32'd100, 32'd7, 4'b0011, 5'd30, 2, TO - 1, 0);
    // No knock-down at all, stuck in ISSUE until the timeout.
    run_txn(32'd1, 32'd2, 4'b0001, 5'd1, 99, -1, 0);

    // Reset during WAIT and during ISSUE, then a write-high request.
    reset_mid(0);
    run_txn(32'h0000_1234, 32'h0000_ABCD, 4'b1000, 5'd12, 0, 0, 0);
    reset_mid(-1);
    run_txn(32'h0000_1234, 32'h0000_ABCD, 4'b1000, 5'd13, 0, 1, 0);

    // ALU done and knock-down held high in IDLE with no request.
    bus.alu_done          = 1'b1;
    bus.alu_en_knock_down = 1'b1;
    bus.alu_out           = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_done_ready", bus.req_ready, 1);
      check("idle_done_wb_valid", bus.wb_valid, 0);
    end
    bus.alu_done          = 1'b0;
    bus.alu_en_knock_down = 1'b0;

    // Randomised transactions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        kd = $urandom_range(0, 9);
        dn = -1;
      end else begin
        kd = $urandom_range(0, 4);
        dn = kd + $urandom_range(0, 6);
      end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_txn($urandom, $urandom, 4'($urandom_range(0, 11)), 5'($urandom), kd, dn, hold);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
